// File: rtl/retire_sched_if.sv
// Retire bus between the ROB head and the retirement scheduler.
// The ROB drives the head lanes; the scheduler returns the commit prefix.
interface retire_sched_if #(
  parameter int WIDTH = 3
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] head_valid;
  logic [WIDTH-1:0] head_done;
  logic [WIDTH-1:0] head_store;
  logic [WIDTH-1:0] head_mispred;
  logic [WIDTH-1:0] head_halt;
  logic [WIDTH-1:0] sq_avail;
  logic [WIDTH-1:0] retire_valid;
  logic [CW-1:0]    retire_count;

  modport master (
    output head_valid,
    output head_done,
    output head_store,
    output head_mispred,
    output head_halt,
    output sq_avail,
    input  retire_valid,
    input  retire_count
  );

  modport slave (
    input  head_valid,
    input  head_done,
    input  head_store,
    input  head_mispred,
    input  head_halt,
    input  sq_avail,
    output retire_valid,
    output retire_count
  );
endinterface

// File: rtl/retire_sched.sv
// In-order retirement scheduler: commit prefix selection, flush and
// recovery sequencing, halt tracking and retired-instruction counting.
module retire_sched #(
  parameter int WIDTH          = 3,
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_W          = 32
) (
  input  logic             clock,
  input  logic             reset,
  retire_sched_if.slave    retire,
  output logic             flush,
  output logic             recovering,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(RECOVER_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN,
    RECOVER,
    HALT
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [RW-1:0]    rcnt_q;
  logic [RW-1:0]    rcnt_d;
  logic             flush_q;
  logic             flush_d;
  logic [CNT_W-1:0] instret_q;

  logic [WIDTH-1:0] sq_run;
  logic [WIDTH-1:0] rv;
  logic [CW-1:0]    cnt;
  logic             mis_hit;
  logic             halt_hit;

  // Only the lowest contiguous run of sq_avail ones grants store slots.
  always_comb begin
    sq_run    = '0;
    sq_run[0] = retire.sq_avail[0];
    for (int k = 1; k < WIDTH; k++)
      sq_run[k] = sq_run[k-1] & retire.sq_avail[k];
  end

  always_comb begin
    logic go;
    logic ok;
    logic sq_ok;
    int   st;
    rv  = '0;
    cnt = '0;
    go  = 1'b1;
    st  = 0;
    for (int i = 0; i < WIDTH; i++) begin
      sq_ok = 1'b0;
      for (int k = 0; k < WIDTH; k++)
        if (k == st) sq_ok = sq_run[k];
      ok = go & retire.head_valid[i] & retire.head_done[i];
      if (retire.head_store[i]) ok = ok & sq_ok;
      if (ok) begin
        rv[i] = 1'b1;
        if (retire.head_store[i]) st = st + 1;
        if (retire.head_mispred[i] | retire.head_halt[i]) go = 1'b0;
      end else begin
        go = 1'b0;
      end
    end
    if (state_q != RUN || reset) rv = '0;
    for (int i = 0; i < WIDTH; i++)
      cnt = cnt + CW'(rv[i]);
  end

  assign mis_hit  = |(rv & retire.head_mispred);
  assign halt_hit = |(rv & retire.head_halt);

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    flush_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (halt_hit) begin
          state_d = HALT;
          flush_d = 1'b1;
        end else if (mis_hit) begin
          state_d = RECOVER;
          flush_d = 1'b1;
          rcnt_d  = RW'(RECOVER_CYCLES);
        end
      end
      RECOVER: begin
        rcnt_d = rcnt_q - RW'(1);
        if (rcnt_q <= RW'(1)) state_d = RUN;
      end
      HALT: state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      rcnt_q    <= '0;
      flush_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      flush_q   <= flush_d;
      instret_q <= instret_q + CNT_W'(cnt);
    end
  end

  assign retire.retire_valid = rv;
  assign retire.retire_count = cnt;
  assign flush      = flush_q;
  assign recovering = (state_q == RECOVER);
  assign halted     = (state_q == HALT);
  assign instret    = instret_q;
endmodule

// File: tb/tb_retire_sched.sv
// Directed bench for retire_sched: prefix rules, recovery, halt, reset
// and counter wrap on a narrow-counter second instance.
module tb_retire_sched;
  logic        clock;
  logic        reset;
  logic        flush;
  logic        recovering;
  logic        halted;
  logic [31:0] instret;
  logic        flush4;
  logic        recovering4;
  logic        halted4;
  logic [3:0]  instret4;
  int          checks;
  int          errors;

  retire_sched_if #(.WIDTH(3)) rif ();
  retire_sched_if #(.WIDTH(3)) rif4 ();

  assign rif4.head_valid   = rif.head_valid;
  assign rif4.head_done    = rif.head_done;
  assign rif4.head_store   = rif.head_store;
  assign rif4.head_mispred = rif.head_mispred;
  assign rif4.head_halt    = rif.head_halt;
  assign rif4.sq_avail     = rif.sq_avail;

  retire_sched #(
    .WIDTH(3), .RECOVER_CYCLES(2), .CNT_W(32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .retire     (rif),
    .flush      (flush),
    .recovering (recovering),
    .halted     (halted),
    .instret    (instret)
  );

  retire_sched #(
    .WIDTH(3), .RECOVER_CYCLES(2), .CNT_W(4)
  ) dut4 (
    .clock      (clock),
    .reset      (reset),
    .retire     (rif4),
    .flush      (flush4),
    .recovering (recovering4),
    .halted     (halted4),
    .instret    (instret4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic set(input logic [2:0] v, input logic [2:0] d,
                     input logic [2:0] s, input logic [2:0] m,
                     input logic [2:0] h, input logic [2:0] q);
    rif.head_valid   = v;
    rif.head_done    = d;
    rif.head_store   = s;
    rif.head_mispred = m;
    rif.head_halt    = h;
    rif.sq_avail     = q;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    set(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111);
    tick();
    chk("rst_rv", 32'(rif.retire_valid), 32'h0);
    chk("rst_cnt", 32'(rif.retire_count), 32'h0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_recov", 32'(recovering), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    reset = 1'b0;
    #1;
    chk("full_rv", 32'(rif.retire_valid), 32'h7);
    chk("full_cnt", 32'(rif.retire_count), 32'd3);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("full_instret", instret, 32'(3 * (k + 1)));
    end

    set(3'b111, 3'b101, 3'b000, 3'b000, 3'b000, 3'b111);
    chk("done_gap_rv", 32'(rif.retire_valid), 32'h1);
    chk("done_gap_cnt", 32'(rif.retire_count), 32'd1);
    tick();
    chk("instret13", instret, 32'd13);

    set(3'b111, 3'b111, 3'b011, 3'b000, 3'b000, 3'b001);
    chk("sq1_rv", 32'(rif.retire_valid), 32'h1);
    tick();
    chk("instret14", instret, 32'd14);
    chk("instret4_14", 32'(instret4), 32'd14);

    set(3'b111, 3'b111, 3'b011, 3'b000, 3'b000, 3'b011);
    chk("sq2_rv", 32'(rif.retire_valid), 32'h7);
    tick();
    chk("instret17", instret, 32'd17);
    chk("instret4_wrap", 32'(instret4), 32'd1);

    set(3'b101, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111);
    chk("valid_gap_rv", 32'(rif.retire_valid), 32'h1);
    tick();
    set(3'b111, 3'b111, 3'b001, 3'b000, 3'b000, 3'b000);
    chk("sq0_rv", 32'(rif.retire_valid), 32'h0);
    chk("sq0_cnt", 32'(rif.retire_count), 32'd0);
    tick();
    chk("instret18", instret, 32'd18);
    set(3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b101);
    chk("sq_nontherm_rv", 32'(rif.retire_valid), 32'h1);
    tick();
    chk("instret19", instret, 32'd19);

    set(3'b111, 3'b111, 3'b000, 3'b010, 3'b000, 3'b111);
    chk("mis_rv", 32'(rif.retire_valid), 32'h3);
    chk("mis_flush_pre", 32'(flush), 32'h0);
    tick();
    chk("rec1_flush", 32'(flush), 32'h1);
    chk("rec1_recov", 32'(recovering), 32'h1);
    chk("rec1_rv", 32'(rif.retire_valid), 32'h0);
    chk("rec1_instret", instret, 32'd21);
    set(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111);
    tick();
    chk("rec2_flush", 32'(flush), 32'h0);
    chk("rec2_recov", 32'(recovering), 32'h1);
    chk("rec2_rv", 32'(rif.retire_valid), 32'h0);
    tick();
    chk("rec_done_recov", 32'(recovering), 32'h0);
    chk("rec_done_rv", 32'(rif.retire_valid), 32'h7);
    chk("rec_done_instret", instret, 32'd21);
    tick();
    chk("instret24", instret, 32'd24);

    set(3'b111, 3'b111, 3'b000, 3'b001, 3'b000, 3'b111);
    chk("mis0_rv", 32'(rif.retire_valid), 32'h1);
    tick();
    chk("rr_recov_pre", 32'(recovering), 32'h1);
    reset = 1'b1;
    tick();
    chk("rr_recov", 32'(recovering), 32'h0);
    chk("rr_flush", 32'(flush), 32'h0);
    chk("rr_instret", instret, 32'd0);
    reset = 1'b0;
    set(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111);
    chk("rr_rv", 32'(rif.retire_valid), 32'h7);
    tick();
    chk("rr_instret3", instret, 32'd3);

    set(3'b111, 3'b111, 3'b000, 3'b001, 3'b001, 3'b111);
    chk("halt_rv", 32'(rif.retire_valid), 32'h1);
    tick();
    chk("halt_flush", 32'(flush), 32'h1);
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_recov", 32'(recovering), 32'h0);
    chk("halt_instret", instret, 32'd4);
    chk("halt_rv0", 32'(rif.retire_valid), 32'h0);
    set(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("halt_hold_flush", 32'(flush), 32'h0);
      chk("halt_hold", 32'(halted), 32'h1);
      chk("halt_hold_rv", 32'(rif.retire_valid), 32'h0);
    end
    chk("halt_hold_instret", instret, 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("halt_rst", 32'(halted), 32'h0);
    chk("halt_rst_rv", 32'(rif.retire_valid), 32'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
